shared_mem_arbiter: RTL and testbench
=====================================

Name: shared_mem_arbiter

Overview:
- Sits between the C cores and the single shared data memory (dmem).
- Round-robin arbiter that serialises main-memory read/write requests from all cores onto one memory port and returns data/acknowledge to the winner.
- Contains a small lock table implementing the cores' lock/unlock protocol on 10-bit lock addresses.

Parameters:
- C, 2, number of cores / requesters.
- L, 4, number of lock-table entries (simultaneously held locks).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- main_mem_read_adr  in  16 x C  per-core read address
- main_mem_write_adr  in  16 x C  per-core write address
- main_mem_write_dat  in  16 x C  per-core write data
- main_mem_read  in  C  per-core read request, held until ack
- main_mem_write  in  C  per-core write request, held until ack
- main_mem_dat  out  16  read data broadcast to all cores, valid with ack
- main_mem_ac  out  C  one-hot access acknowledge
- lock_adr  in  10 x C  per-core lock address
- lock_en  in  C  per-core lock request, held until ack
- unlock_en  in  C  per-core unlock request, held until ack
- lock_ac  out  C  one-hot lock/unlock acknowledge
- mem_adr  out  16  address to dmem
- mem_we  out  1  write enable to dmem
- mem_wdat  out  16  write data to dmem
- mem_rdat  in  16  dmem synchronous read data, one-cycle latency

Behaviour:
- Clock/reset: one clock clk; reset is asynchronous and active-high.
- Reset values: main_mem_ac=0, lock_ac=0, main_mem_dat=0, mem_we=0, mem_adr=0, mem_wdat=0. FSM=IDLE, both round-robin pointers=0, all lock entries invalid.
- Memory FSM, IDLE:
  - Request vector = read|write.
  - If nonzero, pick the first set bit at or after mem_ptr (wrapping mod C) and latch grant index g.
  - Drive mem_adr = write ? write_adr[g] : read_adr[g], mem_we = write[g], mem_wdat = write_dat[g] combinationally this cycle.
  - Go to ACK.
- Memory FSM, ACK:
  - Register main_mem_ac = one-hot(g) and main_mem_dat = mem_rdat.
  - mem_we forced 0; mem_ptr = (g+1) mod C.
  - Return to IDLE.
- Memory timing:
  - Each access occupies 2 cycles, so peak throughput is 1 access per 2 cycles.
  - Ack is seen by the core in the cycle after ACK and lasts exactly one cycle.
  - A core whose main_mem_ac is high is masked from arbitration that cycle; its request is consumed.
- Read and write asserted together by one core: performed as a write only; ack completes both; main_mem_dat is don't-care.
- Lock table: L entries of {valid, adr[9:0], owner[log2 C]}.
- Lock arbitration:
  - Independent of the memory FSM, every cycle.
  - Candidates = (lock_en|unlock_en) & ~lock_ac.
  - Pick one core c round-robin from lock_ptr.
  - lock_ptr advances to c+1 only when c is acked.
- Unlock (unlock_en[c], which has priority over lock_en[c]):
  - Invalidate the entry with matching adr and owner==c, if any.
  - Always ack, even when no entry matches.
- Lock (lock_en[c]):
  - Valid entry with matching adr and owner==c: ack, table unchanged.
  - Valid entry with matching adr and owner≠c: no ack; the core keeps waiting and lock_ptr is not advanced past it, but the other candidates are still scanned next cycle from c+1.
  - No match and a free entry exists: allocate the lowest-index free entry, ack.
  - No match and table full: no ack.
- lock_ac is registered, one cycle after the decision, and one-hot.
- Lock ops do not block memory accesses and vice versa.
- Reset mid-operation: everything returns to reset values immediately; an in-flight access is never acknowledged and all locks are released.

Test Plan:
- Single core 0 write 0x0010←0xBEEF, then read 0x0010 → main_mem_ac=01 two cycles after each request edge; read returns main_mem_dat=0xBEEF; mem_we high exactly one cycle.
- Cores 0 and 1 read simultaneously, continuously re-requesting → acks alternate 01,10,01,10 with a 2-cycle spacing; no core acked twice in a row.
- Core 0 lock 0x05 → lock_ac=01. Core 1 lock 0x05 gets no ack while core 0 holds it. Core 0 unlock 0x05 → lock_ac=01, then core 1 receives lock_ac=10 in a later cycle.
- Fill all L=4 entries from core 0 (0x01..0x04); core 1 lock 0x09 → no ack. Core 0 unlock 0x02 → core 1 acked, and its entry occupies index 1.
- Core 1 unlock 0x33 (never locked) → lock_ac=10, table unchanged. Core 0 re-locks 0x01 it already owns → acked, no new entry.
- Assert reset during the ACK state and while locks are held → no ack is produced; after reset, core 1 lock 0x01 is acked immediately.

Source files
------------

// File: rtl/shared_mem_arbiter.sv
// Shared data-memory arbiter with lock table.
// Serialises per-core dmem reads and writes round-robin onto one memory port.
// Also runs an independent lock/unlock service over a small table of 10-bit lock addresses.
module shared_mem_arbiter #(
  parameter int C = 2,
  parameter int L = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [16*C-1:0] main_mem_read_adr,
  input  logic [16*C-1:0] main_mem_write_adr,
  input  logic [16*C-1:0] main_mem_write_dat,
  input  logic [C-1:0]    main_mem_read,
  input  logic [C-1:0]    main_mem_write,
  output logic [15:0]     main_mem_dat,
  output logic [C-1:0]    main_mem_ac,
  input  logic [10*C-1:0] lock_adr,
  input  logic [C-1:0]    lock_en,
  input  logic [C-1:0]    unlock_en,
  output logic [C-1:0]    lock_ac,
  output logic [15:0]     mem_adr,
  output logic            mem_we,
  output logic [15:0]     mem_wdat,
  input  logic [15:0]     mem_rdat
);

  localparam int GW = (C > 1) ? $clog2(C) : 1;

  typedef enum logic {IDLE, ACK} state_t;

  // (base + off) mod C without a divider; off is always below C.
  function automatic logic [GW-1:0] wrap_add(input logic [GW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= C) s = s - C;
    return GW'(s);
  endfunction

  // ---------------- memory side ----------------
  state_t          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   mem_ptr_q, mem_ptr_d;
  logic [C-1:0]    main_mem_ac_q, main_mem_ac_d;
  logic [15:0]     main_mem_dat_q, main_mem_dat_d;
  logic [C-1:0]    mem_req;
  logic            mem_found;
  logic [GW-1:0]   mem_sel;
  logic [GW-1:0]   mem_idx;

  // Round-robin pick among requesters; a core being acked this cycle is masked.
  always_comb begin
    mem_req   = (main_mem_read | main_mem_write) & ~main_mem_ac_q;
    mem_found = 1'b0;
    mem_sel   = '0;
    mem_idx   = '0;
    for (int i = 0; i < C; i++) begin
      mem_idx = wrap_add(mem_ptr_q, i);
      if (!mem_found && mem_req[mem_idx]) begin
        mem_found = 1'b1;
        mem_sel   = mem_idx;
      end
    end
  end

  // dmem port is driven combinationally in the grant cycle; gated by reset so nothing is written while held in reset.
  always_comb begin
    mem_adr  = '0;
    mem_we   = 1'b0;
    mem_wdat = '0;
    if (state_q == IDLE && mem_found && !reset) begin
      mem_we   = main_mem_write[mem_sel];
      mem_adr  = main_mem_write[mem_sel] ? main_mem_write_adr[mem_sel*16 +: 16]
                                         : main_mem_read_adr[mem_sel*16 +: 16];
      mem_wdat = main_mem_write_dat[mem_sel*16 +: 16];
    end
  end

  // Two-state access FSM: grant in IDLE, capture dmem read data and ack in ACK.
  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    mem_ptr_d      = mem_ptr_q;
    main_mem_ac_d  = '0;
    main_mem_dat_d = main_mem_dat_q;
    case (state_q)
      IDLE: begin
        if (mem_found) begin
          grant_d = mem_sel;
          state_d = ACK;
        end
      end
      ACK: begin
        main_mem_ac_d[grant_q] = 1'b1;
        main_mem_dat_d         = mem_rdat;
        mem_ptr_d              = wrap_add(grant_q, 1);
        state_d                = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------- lock side ----------------
  logic [L-1:0]  tbl_valid_q, tbl_valid_d;
  logic [9:0]    tbl_adr_q   [L];
  logic [9:0]    tbl_adr_d   [L];
  logic [GW-1:0] tbl_owner_q [L];
  logic [GW-1:0] tbl_owner_d [L];
  logic [GW-1:0] lock_ptr_q, lock_ptr_d;
  logic [GW-1:0] lock_scan_q, lock_scan_d;
  logic [C-1:0]  lock_ac_q, lock_ac_d;
  logic [C-1:0]  lk_cand;
  logic          lk_found;
  logic [GW-1:0] lk_sel;
  logic [GW-1:0] lk_idx;
  logic [9:0]    lk_adr;
  logic [L-1:0]  adr_hit;
  logic [L-1:0]  own_hit;
  logic          free_found;
  logic          lk_ack;

  // Pick one lock candidate; the scan restarts after the last core examined so a blocked core cannot starve the rest.
  always_comb begin
    lk_cand  = (lock_en | unlock_en) & ~lock_ac_q;
    lk_found = 1'b0;
    lk_sel   = '0;
    lk_idx   = '0;
    for (int i = 0; i < C; i++) begin
      lk_idx = wrap_add(lock_scan_q, i);
      if (!lk_found && lk_cand[lk_idx]) begin
        lk_found = 1'b1;
        lk_sel   = lk_idx;
      end
    end
    lk_adr = lock_adr[lk_sel*10 +: 10];
  end

  genvar gi;
  generate
    for (gi = 0; gi < L; gi++) begin : g_entry
      assign adr_hit[gi] = tbl_valid_q[gi] && (tbl_adr_q[gi] == lk_adr);
      assign own_hit[gi] = adr_hit[gi] && (tbl_owner_q[gi] == lk_sel);
    end
  endgenerate

  // Lock/unlock decision and table update for the selected core; unlock wins over lock.
  always_comb begin
    tbl_valid_d = tbl_valid_q;
    tbl_adr_d   = tbl_adr_q;
    tbl_owner_d = tbl_owner_q;
    lk_ack      = 1'b0;
    free_found  = 1'b0;
    if (lk_found) begin
      if (unlock_en[lk_sel]) begin
        tbl_valid_d = tbl_valid_q & ~own_hit;
        lk_ack      = 1'b1;
      end else if (|own_hit) begin
        lk_ack = 1'b1;
      end else if (!(|adr_hit)) begin
        for (int j = 0; j < L; j++) begin
          if (!free_found && !tbl_valid_q[j]) begin
            free_found     = 1'b1;
            tbl_valid_d[j] = 1'b1;
            tbl_adr_d[j]   = lk_adr;
            tbl_owner_d[j] = lk_sel;
          end
        end
        lk_ack = free_found;
      end
    end
    lock_ac_d = '0;
    if (lk_ack) lock_ac_d[lk_sel] = 1'b1;
    lock_ptr_d  = lk_ack ? wrap_add(lk_sel, 1) : lock_ptr_q;
    lock_scan_d = lk_found ? wrap_add(lk_sel, 1) : lock_ptr_q;
  end

  // All state registers; async reset drops any in-flight access and releases every lock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      grant_q        <= '0;
      mem_ptr_q      <= '0;
      main_mem_ac_q  <= '0;
      main_mem_dat_q <= '0;
      tbl_valid_q    <= '0;
      lock_ptr_q     <= '0;
      lock_scan_q    <= '0;
      lock_ac_q      <= '0;
      for (int j = 0; j < L; j++) begin
        tbl_adr_q[j]   <= '0;
        tbl_owner_q[j] <= '0;
      end
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      mem_ptr_q      <= mem_ptr_d;
      main_mem_ac_q  <= main_mem_ac_d;
      main_mem_dat_q <= main_mem_dat_d;
      tbl_valid_q    <= tbl_valid_d;
      lock_ptr_q     <= lock_ptr_d;
      lock_scan_q    <= lock_scan_d;
      lock_ac_q      <= lock_ac_d;
      for (int j = 0; j < L; j++) begin
        tbl_adr_q[j]   <= tbl_adr_d[j];
        tbl_owner_q[j] <= tbl_owner_d[j];
      end
    end
  end

  assign main_mem_ac  = main_mem_ac_q;
  assign main_mem_dat = main_mem_dat_q;
  assign lock_ac      = lock_ac_q;

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Directed bench for shared_mem_arbiter (C=2, L=4) with a behavioural synchronous dmem.
module tb_shared_mem_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] main_mem_read_adr = '0;
  logic [31:0] main_mem_write_adr = '0;
  logic [31:0] main_mem_write_dat = '0;
  logic [1:0]  main_mem_read = '0;
  logic [1:0]  main_mem_write = '0;
  logic [15:0] main_mem_dat;
  logic [1:0]  main_mem_ac;
  logic [19:0] lock_adr = '0;
  logic [1:0]  lock_en = '0;
  logic [1:0]  unlock_en = '0;
  logic [1:0]  lock_ac;
  logic [15:0] mem_adr;
  logic        mem_we;
  logic [15:0] mem_wdat;
  logic [15:0] mem_rdat = '0;
  logic [15:0] dmem [0:1023];

  int pass_cnt = 0;
  int total_cnt = 0;

  shared_mem_arbiter #(.C(2), .L(4)) dut (
    .clk(clk), .reset(reset),
    .main_mem_read_adr(main_mem_read_adr), .main_mem_write_adr(main_mem_write_adr),
    .main_mem_write_dat(main_mem_write_dat), .main_mem_read(main_mem_read),
    .main_mem_write(main_mem_write), .main_mem_dat(main_mem_dat), .main_mem_ac(main_mem_ac),
    .lock_adr(lock_adr), .lock_en(lock_en), .unlock_en(unlock_en), .lock_ac(lock_ac),
    .mem_adr(mem_adr), .mem_we(mem_we), .mem_wdat(mem_wdat), .mem_rdat(mem_rdat)
  );

  always #5 clk = ~clk;

  // dmem: one-cycle registered read, write on clock edge
  always @(posedge clk) begin
    mem_rdat <= dmem[mem_adr[9:0]];
    if (mem_we) dmem[mem_adr[9:0]] <= mem_wdat;
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    main_mem_read = '0; main_mem_write = '0; lock_en = '0; unlock_en = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    total_cnt++; if (main_mem_ac !== 2'b00) $display("FAIL rst_ac: got %b want 00", main_mem_ac); else pass_cnt++;
    total_cnt++; if (lock_ac !== 2'b00) $display("FAIL rst_lock_ac: got %b want 00", lock_ac); else pass_cnt++;
    total_cnt++; if (main_mem_dat !== 16'h0) $display("FAIL rst_dat: got %h want 0000", main_mem_dat); else pass_cnt++;
    total_cnt++; if ({mem_we, mem_adr, mem_wdat} !== 33'h0) $display("FAIL rst_mem_port: got %b/%h/%h want 0/0000/0000", mem_we, mem_adr, mem_wdat); else pass_cnt++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_single_write_read();
    @(negedge clk);
    main_mem_write[0] = 1'b1; main_mem_write_adr[15:0] = 16'h0010; main_mem_write_dat[15:0] = 16'hBEEF;
    #1;
    total_cnt++; if (mem_we !== 1'b1) $display("FAIL wr_we: got %b want 1", mem_we); else pass_cnt++;
    total_cnt++; if (mem_adr !== 16'h0010) $display("FAIL wr_adr: got %h want 0010", mem_adr); else pass_cnt++;
    total_cnt++; if (mem_wdat !== 16'hBEEF) $display("FAIL wr_wdat: got %h want beef", mem_wdat); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (main_mem_ac !== 2'b00) $display("FAIL wr_ac_early: got %b want 00", main_mem_ac); else pass_cnt++;
    total_cnt++; if (mem_we !== 1'b0) $display("FAIL wr_we_ack: got %b want 0", mem_we); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (main_mem_ac !== 2'b01) $display("FAIL wr_ac: got %b want 01", main_mem_ac); else pass_cnt++;
    total_cnt++; if (mem_we !== 1'b0) $display("FAIL wr_we_after: got %b want 0", mem_we); else pass_cnt++;
    main_mem_write[0] = 1'b0;
    @(negedge clk);
    total_cnt++; if (main_mem_ac !== 2'b00) $display("FAIL wr_ac_one_cycle: got %b want 00", main_mem_ac); else pass_cnt++;
    main_mem_read[0] = 1'b1; main_mem_read_adr[15:0] = 16'h0010;
    #1;
    total_cnt++; if ({mem_we, mem_adr} !== {1'b0, 16'h0010}) $display("FAIL rd_port: got %b/%h want 0/0010", mem_we, mem_adr); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (main_mem_ac !== 2'b00) $display("FAIL rd_ac_early: got %b want 00", main_mem_ac); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (main_mem_ac !== 2'b01) $display("FAIL rd_ac: got %b want 01", main_mem_ac); else pass_cnt++;
    total_cnt++; if (main_mem_dat !== 16'hBEEF) $display("FAIL rd_dat: got %h want beef", main_mem_dat); else pass_cnt++;
    main_mem_read[0] = 1'b0;
    $display("single core write/read done");
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_ac;
    do_reset();
    @(negedge clk);
    main_mem_read_adr = {16'h0020, 16'h0010};
    main_mem_read = 2'b11;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      exp_ac = (k % 2 == 1) ? 2'b00 : ((k % 4 == 2) ? 2'b01 : 2'b10);
      total_cnt++; if (main_mem_ac !== exp_ac) $display("FAIL rr_ac[%0d]: got %b want %b", k, main_mem_ac, exp_ac); else pass_cnt++;
    end
    main_mem_read = 2'b00;
    @(negedge clk);
    $display("round-robin reads done");
  endtask

  task automatic test_lock_contention();
    do_reset();
    @(negedge clk);
    lock_en[0] = 1'b1; lock_adr[9:0] = 10'h005;
    @(negedge clk);
    total_cnt++; if (lock_ac !== 2'b01) $display("FAIL lk0_ac: got %b want 01", lock_ac); else pass_cnt++;
    lock_en[0] = 1'b0;
    lock_en[1] = 1'b1; lock_adr[19:10] = 10'h005;
    @(negedge clk);
    total_cnt++; if (lock_ac !== 2'b00) $display("FAIL lk1_blocked_a: got %b want 00", lock_ac); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (lock_ac !== 2'b00) $display("FAIL lk1_blocked_b: got %b want 00", lock_ac); else pass_cnt++;
    unlock_en[0] = 1'b1;
    @(negedge clk);
    total_cnt++; if (lock_ac !== 2'b01) $display("FAIL unlk0_ac: got %b want 01", lock_ac); else pass_cnt++;
    unlock_en[0] = 1'b0;
    @(negedge clk);
    total_cnt++; if (lock_ac !== 2'b10) $display("FAIL lk1_ac: got %b want 10", lock_ac); else pass_cnt++;
    lock_en[1] = 1'b0;
    @(negedge clk);
    $display("lock contention done");
  endtask

  task automatic test_table_full();
    do_reset();
    for (int a = 1; a <= 4; a++) begin
      @(negedge clk);
      lock_en[0] = 1'b1; lock_adr[9:0] = 10'(a);
      @(negedge clk);
      total_cnt++; if (lock_ac !== 2'b01) $display("FAIL fill_ac[%0d]: got %b want 01", a, lock_ac); else pass_cnt++;
      lock_en[0] = 1'b0;
    end
    @(negedge clk);
    lock_en[1] = 1'b1; lock_adr[19:10] = 10'h009;
    @(negedge clk);
    total_cnt++; if (lock_ac !== 2'b00) $display("FAIL full_a: got %b want 00", lock_ac); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (lock_ac !== 2'b00) $display("FAIL full_b: got %b want 00", lock_ac); else pass_cnt++;
    unlock_en[0] = 1'b1; lock_adr[9:0] = 10'h002;
    @(negedge clk);
    total_cnt++; if (lock_ac !== 2'b01) $display("FAIL unlk2_ac: got %b want 01", lock_ac); else pass_cnt++;
    unlock_en[0] = 1'b0;
    @(negedge clk);
    total_cnt++; if (lock_ac !== 2'b10) $display("FAIL lk9_ac: got %b want 10", lock_ac); else pass_cnt++;
    lock_en[1] = 1'b0;
    total_cnt++; if (dut.tbl_valid_q !== 4'b1111) $display("FAIL lk9_valid: got %b want 1111", dut.tbl_valid_q); else pass_cnt++;
    total_cnt++; if (dut.tbl_adr_q[1] !== 10'h009) $display("FAIL lk9_entry_adr: got %h want 009", dut.tbl_adr_q[1]); else pass_cnt++;
    total_cnt++; if (dut.tbl_owner_q[1] !== 1'b1) $display("FAIL lk9_entry_owner: got %b want 1", dut.tbl_owner_q[1]); else pass_cnt++;
    @(negedge clk);
    $display("lock table full done");
  endtask

  task automatic test_unlock_unheld_relock();
    @(negedge clk);
    unlock_en[1] = 1'b1; lock_adr[19:10] = 10'h033;
    @(negedge clk);
    total_cnt++; if (lock_ac !== 2'b10) $display("FAIL unlk33_ac: got %b want 10", lock_ac); else pass_cnt++;
    total_cnt++; if (dut.tbl_valid_q !== 4'b1111) $display("FAIL unlk33_valid: got %b want 1111", dut.tbl_valid_q); else pass_cnt++;
    unlock_en[1] = 1'b0;
    @(negedge clk);
    lock_en[0] = 1'b1; lock_adr[9:0] = 10'h001;
    @(negedge clk);
    total_cnt++; if (lock_ac !== 2'b01) $display("FAIL relock_ac: got %b want 01", lock_ac); else pass_cnt++;
    total_cnt++; if (dut.tbl_valid_q !== 4'b1111) $display("FAIL relock_valid: got %b want 1111", dut.tbl_valid_q); else pass_cnt++;
    total_cnt++; if (dut.tbl_adr_q[0] !== 10'h001) $display("FAIL relock_entry0: got %h want 001", dut.tbl_adr_q[0]); else pass_cnt++;
    lock_en[0] = 1'b0;
    @(negedge clk);
    $display("unheld unlock / relock done");
  endtask

  task automatic test_reset_midop();
    @(negedge clk);
    main_mem_read[0] = 1'b1; main_mem_read_adr[15:0] = 16'h0010;
    @(negedge clk);
    reset = 1'b1;
    #1;
    total_cnt++; if (main_mem_ac !== 2'b00) $display("FAIL midrst_ac_a: got %b want 00", main_mem_ac); else pass_cnt++;
    total_cnt++; if (dut.tbl_valid_q !== 4'b0000) $display("FAIL midrst_valid: got %b want 0000", dut.tbl_valid_q); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (main_mem_ac !== 2'b00) $display("FAIL midrst_ac_b: got %b want 00", main_mem_ac); else pass_cnt++;
    reset = 1'b0;
    main_mem_read = 2'b00;
    @(negedge clk);
    total_cnt++; if (main_mem_ac !== 2'b00) $display("FAIL midrst_ac_c: got %b want 00", main_mem_ac); else pass_cnt++;
    lock_en[1] = 1'b1; lock_adr[19:10] = 10'h001;
    @(negedge clk);
    total_cnt++; if (lock_ac !== 2'b10) $display("FAIL postrst_lock: got %b want 10", lock_ac); else pass_cnt++;
    lock_en[1] = 1'b0;
    @(negedge clk);
    $display("reset mid-operation done");
  endtask

  initial begin
    test_reset();
    test_single_write_read();
    test_back_to_back();
    test_lock_contention();
    test_table_full();
    test_unlock_unheld_relock();
    test_reset_midop();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
